// File: rtl/pwm_pkg.sv
// Shared types and constant helpers for the multi-channel PWM bank.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_e;

  // Period in clocks for a given counter width: 2^width - 1.
  function automatic int unsigned period(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Phase offset of channel i when edges are staggered across the period.
  function automatic int unsigned phase_off(input int unsigned i,
                                            input int unsigned channels,
                                            input int unsigned width);
    return (i * period(width)) / channels;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM lane: offsets the shared counter by a fixed phase, compares against duty.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OFF   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned P  = period(WIDTH);

  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] ph_c;

  // cnt and OFF are both below P, so one conditional subtract keeps phase in range.
  always_comb begin
    sum_c = {1'b0, cnt} + SW'(OFF);
    if (sum_c >= SW'(P)) begin
      sum_c = sum_c - SW'(P);
    end
    ph_c = sum_c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 1'b0;
    end else if (en) begin
      pwm <= (ph_c < duty);
    end
  end

endmodule

// File: rtl/pwm_bank_gen.sv
// Multi-channel PWM bank: shared period counter, serial duty load, commit at period boundary.
module pwm_bank_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STAGGER  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sdi,
  input  logic                shift,
  input  logic                latch,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_tick,
  output logic                pending
);

  localparam int unsigned P   = period(WIDTH);
  localparam int unsigned SHW = CHANNELS * WIDTH;

  logic [WIDTH-1:0]                 cnt;
  logic [SHW-1:0]                   shadow;
  logic [CHANNELS-1:0][WIDTH-1:0]   active;
  commit_state_e                    state, state_nxt;
  logic                             wrap_c;
  logic                             commit_c;

  assign wrap_c  = en && (cnt == WIDTH'(P - 1));
  assign pending = (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + WIDTH'(1);
    end
  end

  // Shadow loads independently of en; channel CHANNELS-1 MSB enters first.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (shift) begin
      shadow <= {shadow[SHW-2:0], sdi};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
    end else if (commit_c) begin
      active <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A latch landing on the wrap edge commits immediately without entering PEND.
  always_comb begin
    state_nxt = state;
    commit_c  = 1'b0;
    case (state)
      IDLE: begin
        if (latch && wrap_c) begin
          commit_c = 1'b1;
        end else if (latch) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (wrap_c) begin
          commit_c  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap_c;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH (WIDTH),
      .OFF   ((STAGGER != 0) ? phase_off(i, CHANNELS, WIDTH) : 32'd0)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .cnt  (cnt),
      .duty (active[i]),
      .pwm  (pwm[i])
    );
  end

endmodule

// File: doc/pwm_bank_gen.md
# pwm_bank_gen

Parametrised multi-channel PWM generator; next generation of the fixed 8-channel generator. It drives CHANNELS PWM outputs from one shared free-running period counter. Per-channel duty values are loaded through a serial shift-register port and committed glitch-free at the period boundary. An optional phase-stagger mode spreads channel edges across the period to reduce simultaneous switching.

## Interface
- CHANNELS, 8, number of PWM outputs (≥1).
- WIDTH, 8, duty/counter width in bits (2..16); period P = 2^WIDTH − 1 clocks.
- STAGGER, 0, 0 = all channels phase-aligned; 1 = channel i phase-offset by OFF_i = (i·P) / CHANNELS (integer division).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  counter/output advance enable; low freezes counter, pwm and pending commit.
- sdi  in  1  serial duty data, MSB first.
- shift  in  1  when high, shadow register shifts left one bit, sdi enters LSB.
- latch  in  1  one-cycle request to commit shadow to active duties at next period boundary.
- pwm  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  one-cycle pulse marking start of a new period.
- pending  out  1  high while a latch request awaits commit.

## Operation
- Shadow register: CHANNELS·WIDTH bits; bits [(i+1)·WIDTH−1 : i·WIDTH] = duty of channel i. Full load = CHANNELS·WIDTH shift cycles; first bit shifted is the MSB of channel CHANNELS−1. Shifting is independent of en.
- Active duty registers: CHANNELS × WIDTH, written only at commit.
- Counter cnt counts 0..P−1 while en=1; at cnt = P−1 it wraps to 0 (wrap edge).
- Phase: ph_i = cnt (STAGGER=0); ph_i = cnt + OFF_i, minus P if ≥ P (STAGGER=1). Result always in 0..P−1, WIDTH bits.
- Output: pwm[i] ← (ph_i < duty_i), unsigned compare. duty 0 → constant low; duty P (all ones) → constant high; duty d → exactly d high clocks per period.
- Commit FSM, two states: IDLE (pending=0) and PEND (pending=1).
  - IDLE → PEND on latch=1.
  - PEND → IDLE at wrap edge with en=1; at that edge active ← shadow.
  - latch in PEND: no effect (stays PEND).
  - latch on the wrap-edge cycle itself: commit occurs at that edge, pending never rises.
  - shift concurrent with commit edge: commit takes shadow value before that edge's shift.
- en=0: cnt, pwm, active, FSM state hold; shift and latch (IDLE→PEND) still act.

## Timing
- Reset values: cnt=0, shadow=0, active=0, FSM=IDLE, pwm=all 0, period_tick=0, pending=0.
- pwm is registered: it reflects cnt/active of the previous cycle (1-cycle latency).
- period_tick=1 in the cycle after each wrap edge with en=1, i.e. while cnt=0. Never asserted after reset alone.
- New duty first appears on pwm at the edge ending the period_tick cycle.
- First wrap edge after reset occurs P en-cycles after reset release.
- Reset mid-load or mid-pending discards shadow contents and the request.

## Structure
- Package pwm_pkg: function period(WIDTH) = 2^WIDTH−1; function phase_off(i, CHANNELS, WIDTH); FSM state enum {IDLE, PEND}.
- Sub-module pwm_channel (one per channel, generate loop): phase add/wrap, compare, pwm output flop. Parameters: WIDTH, OFF. Inputs: cnt, duty, en.
- Top module holds counter, shadow shift register, active registers, FSM and period_tick.

## Test plan
- Reset: hold rst 3 cycles with en=1 and sdi=1 toggling shift → pwm=0, pending=0, period_tick=0; first period_tick arrives 255 cycles after release (WIDTH=8).
- Load and commit (CHANNELS=8, WIDTH=8): shift in duties 0,1,64,128,200,254,255,17, then latch → pending=1 until wrap. Following period: high counts are 0,1,64,128,200,254,255,17 of 255; ch6 constant high, ch0 constant low.
- Glitch-free update: change ch2 duty 64→10 mid-period and latch at cnt=30 → current period still shows 64 highs; next period shows 10.
- Stagger (STAGGER=1, CHANNELS=4, WIDTH=4, P=15): all duties 5 → offsets 0,3,7,11. ch1 rises 3 cycles before ch0's relative edge; each channel gives 5 highs per 15.
- en gating: drop en for 20 cycles mid-period with latch pending → pwm and cnt frozen, pending stays 1; commit happens at the first wrap after en returns.
- Simultaneous events: latch on the wrap-edge cycle → commit at that edge, pending stays 0. Shift on the commit edge → committed duty excludes that shifted bit.
